// File: rtl/wbcon_rx.sv
// Receive side of the Wishbone console link: turns host command bytes into
// executor memory requests, with an auto-incrementing address register.
module wbcon_rx #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic                    o_mreq_valid,
  input  logic                    i_mreq_ready,
  output logic                    o_mreq_we,
  output logic [8*ADDR_BYTES-1:0] o_mreq_addr,
  output logic [8*DATA_BYTES-1:0] o_mreq_wdata
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [1:0] {
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_REQ
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_sh;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   byte_cnt;
  logic [4:0]      remaining;
  logic            inc_q;
  logic            we_q;

  logic            byte_fire;
  logic [AW-1:0]   addr_shift_next;
  logic [DW-1:0]   wdata_shift_next;

  assign o_rx_ready   = i_rst_n && (state != S_REQ);
  assign o_mreq_valid = (state == S_REQ);
  assign o_mreq_we    = we_q;
  assign o_mreq_addr  = addr_q;
  assign o_mreq_wdata = wdata_q;

  assign byte_fire = i_rx_valid && o_rx_ready;

  // Payload arrives LSB first, so each new byte enters at the top and slides down.
  assign addr_shift_next  = (addr_sh >> 8) | (AW'(i_rx_data) << (AW - 8));
  assign wdata_shift_next = (wdata_q >> 8) | (DW'(i_rx_data) << (DW - 8));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_CMD;
      addr_q    <= '0;
      addr_sh   <= '0;
      wdata_q   <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      inc_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        S_CMD: begin
          if (byte_fire) begin
            inc_q    <= i_rx_data[5];
            byte_cnt <= '0;
            case (i_rx_data[7:6])
              2'b01: state <= S_ADDR;
              2'b10: state <= S_WDATA;
              2'b11: begin
                remaining <= i_rx_data[4:0];
                we_q      <= 1'b0;
                state     <= S_REQ;
              end
              default: state <= S_CMD;
            endcase
          end
        end

        // The live address only changes once the whole new address is in.
        S_ADDR: begin
          if (byte_fire) begin
            if (byte_cnt == CW'(ADDR_BYTES - 1)) begin
              addr_q <= addr_shift_next;
              state  <= S_CMD;
            end else begin
              addr_sh  <= addr_shift_next;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (byte_fire) begin
            wdata_q <= wdata_shift_next;
            if (byte_cnt == CW'(DATA_BYTES - 1)) begin
              we_q      <= 1'b1;
              remaining <= '0;
              state     <= S_REQ;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_REQ: begin
          if (i_mreq_ready) begin
            if (inc_q) addr_q <= addr_q + AW'(1);
            if (remaining == 5'd0) state <= S_CMD;
            else remaining <= remaining - 5'd1;
          end
        end

        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_wbcon_rx.sv
// Randomized bench for wbcon_rx: a stream interpreter predicts the request
// sequence, and each accepted request is compared against it.
module tb_wbcon_rx;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_mreq_valid;
  logic        i_mreq_ready = 1'b0;
  logic        o_mreq_we;
  logic [23:0] o_mreq_addr;
  logic [31:0] o_mreq_wdata;

  wbcon_rx #(.ADDR_BYTES(3), .DATA_BYTES(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_mreq_valid (o_mreq_valid),
    .i_mreq_ready (i_mreq_ready),
    .o_mreq_we    (o_mreq_we),
    .o_mreq_addr  (o_mreq_addr),
    .o_mreq_wdata (o_mreq_wdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  stim_q[$];
  bit          end_q[$];
  req_t        exp_q[$];
  logic [23:0] model_addr = 24'h0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Interpret the whole byte stream as frames and list the requests it implies.
  task automatic buildModel();
    int i = 0;
    int n = stim_q.size();
    exp_q.delete();
    end_q.delete();
    for (int k = 0; k < n; k++) end_q.push_back(1'b0);
    while (i < n) begin
      logic [7:0] c = stim_q[i];
      case (c[7:6])
        2'b00: i += 1;
        2'b01: begin
          model_addr = {stim_q[i+3], stim_q[i+2], stim_q[i+1]};
          i += 4;
        end
        2'b10: begin
          req_t r;
          r.we = 1'b1;
          r.addr = model_addr;
          r.wdata = {stim_q[i+4], stim_q[i+3], stim_q[i+2], stim_q[i+1]};
          exp_q.push_back(r);
          if (c[5]) model_addr = model_addr + 24'd1;
          end_q[i+4] = 1'b1;
          i += 5;
        end
        default: begin
          for (int k = 0; k <= int'(c[4:0]); k++) begin
            req_t r;
            r.we = 1'b0;
            r.addr = model_addr;
            r.wdata = 32'h0;
            exp_q.push_back(r);
            if (c[5]) model_addr = model_addr + 24'd1;
          end
          end_q[i] = 1'b1;
          i += 1;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input int gap_pct, input int stall_pct);
    int   idx = 0;
    int   n;
    int   cycles = 0;
    bit   expect_valid = 1'b0;
    bit   prev_pending = 1'b0;
    req_t prev;
    buildModel();
    n = stim_q.size();
    forever begin
      @(negedge i_clk);
      if (idx == n && exp_q.size() == 0 && !expect_valid) break;
      if (cycles++ > 20000) begin
        checkOutput("timeout", 64'd1, 64'd0);
        break;
      end
      i_rx_valid   = (idx < n) && ($urandom_range(99, 0) >= gap_pct);
      i_rx_data    = (idx < n) ? stim_q[idx] : 8'h00;
      i_mreq_ready = ($urandom_range(99, 0) >= stall_pct);
      #1;
      if (expect_valid) checkOutput("latency", {63'd0, o_mreq_valid}, 64'd1);
      expect_valid = 1'b0;
      checkOutput("rx_ready", {63'd0, o_rx_ready}, {63'd0, !o_mreq_valid});
      if (prev_pending) begin
        checkOutput("hold_valid", {63'd0, o_mreq_valid}, 64'd1);
        checkOutput("hold_fields", {7'd0, o_mreq_we, o_mreq_addr, o_mreq_wdata},
                    {7'd0, prev.we, prev.addr, prev.wdata});
      end
      prev_pending = o_mreq_valid && !i_mreq_ready;
      prev.we = o_mreq_we;
      prev.addr = o_mreq_addr;
      prev.wdata = o_mreq_wdata;
      if (o_mreq_valid && i_mreq_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", 64'd1, 64'd0);
        end else begin
          req_t r = exp_q.pop_front();
          checkOutput("req_we", {63'd0, o_mreq_we}, {63'd0, r.we});
          checkOutput("req_addr", {40'd0, o_mreq_addr}, {40'd0, r.addr});
          if (r.we) checkOutput("req_wdata", {32'd0, o_mreq_wdata}, {32'd0, r.wdata});
        end
      end
      if (i_rx_valid && o_rx_ready) begin
        if (end_q[idx]) expect_valid = 1'b1;
        idx++;
      end
    end
    i_rx_valid   = 1'b0;
    i_mreq_ready = 1'b0;
    #1;
    checkOutput("idle_valid", {63'd0, o_mreq_valid}, 64'd0);
    checkOutput("leftover", 64'(exp_q.size()), 64'd0);
    checkOutput("addr_reg", {40'd0, o_mreq_addr}, {40'd0, model_addr});
  endtask

  task automatic driveByte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("rst_valid", {63'd0, o_mreq_valid}, 64'd0);
    checkOutput("rst_ready", {63'd0, o_rx_ready}, 64'd0);
    checkOutput("rst_addr", {40'd0, o_mreq_addr}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_addr = 24'h0;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_valid", {63'd0, o_mreq_valid}, 64'd0);
    checkOutput("reset_ready", {63'd0, o_rx_ready}, 64'd0);
    checkOutput("reset_we", {63'd0, o_mreq_we}, 64'd0);
    checkOutput("reset_addr", {40'd0, o_mreq_addr}, 64'd0);
    checkOutput("reset_wdata", {32'd0, o_mreq_wdata}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {63'd0, o_rx_ready}, 64'd1);

    stim_q = {8'h40, 8'h56, 8'h34, 8'h12};
    applyStimulus(0, 0);
    checkOutput("setaddr_value", {40'd0, o_mreq_addr}, 64'h123456);

    stim_q = {8'h40, 8'h10, 8'h00, 8'h00, 8'hA0, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'hA0, 8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(0, 70);

    stim_q = {8'h40, 8'h20, 8'h00, 8'h00, 8'hE3};
    applyStimulus(0, 0);

    stim_q = {8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hC1, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hE1};
    applyStimulus(0, 20);

    stim_q = {8'h40, 8'h10, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(50, 0);

    for (int round = 0; round < 6; round++) begin
      stim_q.delete();
      for (int f = 0; f < 25; f++) begin
        logic [1:0]  op   = 2'($urandom_range(3, 0));
        logic [5:0]  low  = 6'($urandom);
        logic [23:0] a    = ($urandom_range(3, 0) == 0) ? (24'hFFFFF0 | 24'($urandom_range(15, 0)))
                                                         : 24'($urandom);
        stim_q.push_back({op, low});
        if (op == 2'b01) begin
          stim_q.push_back(a[7:0]);
          stim_q.push_back(a[15:8]);
          stim_q.push_back(a[23:16]);
        end else if (op == 2'b10) begin
          for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom));
        end
      end
      applyStimulus(10 * round, 10 * (5 - round));
    end

    driveByte(8'hA0);
    driveByte(8'h11);
    driveByte(8'h22);
    doReset();
    stim_q = {8'hC0};
    applyStimulus(0, 0);

    driveByte(8'h40);
    driveByte(8'h55);
    driveByte(8'h00);
    driveByte(8'h00);
    driveByte(8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_mreq_ready = 1'b1;
      #1;
      checkOutput("burst_valid", {63'd0, o_mreq_valid}, 64'd1);
      checkOutput("burst_addr", {40'd0, o_mreq_addr}, 64'(24'h55 + k));
    end
    doReset();
    i_mreq_ready = 1'b0;
    stim_q = {8'hC0};
    applyStimulus(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
